// File: rtl/pwl_muladd_float.sv
// Multi-cycle truncating float multiply-add y = m*data + c for the piecewise-linear activation.
// Optional: define PWL_ZERO_SLOPE_FASTPATH_EN to bypass the datapath when the slope is zero.
module pwl_muladd_float #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   data,
    input  logic [EXP_W+MAN_W:0]   m,
    input  logic [EXP_W+MAN_W:0]   c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic                   busy
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 1;
    localparam int PW  = 2 * MW;
    localparam int EW  = EXP_W + 3;
    localparam int LZW = $clog2(MW + 1);

    localparam logic [EXP_W-1:0]    E_ONES = '1;
    localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] SHMAX  = EW'(MAN_W + 3);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E = '0;
    localparam logic [W-1:0]         NAN_W  = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0]         MAXMAG = {E_ONES - 1'b1, {MAN_W{1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_ALIGN, S_ADD, S_NORM, S_DONE} state_e;

    function automatic logic [EXP_W-1:0] exp_f(input logic [W-1:0] x);
        return x[W-2:MAN_W];
    endfunction

    function automatic logic [MAN_W-1:0] man_f(input logic [W-1:0] x);
        return x[MAN_W-1:0];
    endfunction

    state_e                 state_q, state_d;
    logic [W-1:0]           data_q, data_d, m_q, m_d, c_q, c_d, y_q, y_d;
    logic [PW-1:0]          prod_q, prod_d;
    logic signed [EW-1:0]   pe_q, pe_d, ae_q, ae_d;
    logic                   ps_q, ps_d, nan_q, nan_d, pzero_q, pzero_d;
    logic [MW-1:0]          a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic                   sa_q, sa_d, sb_q, sb_d;
    logic [MW:0]            sum_q, sum_d;
    logic                   rs_q, rs_d, rzero_q, rzero_d;

    logic [MW-1:0]          mp, mc, man_n;
    logic signed [EW-1:0]   ep, ec, diff, e_n;
    logic [LZW-1:0]         lzc;
    logic                   unused_bits;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;   m_d     = m_q;     c_d     = c_q;     y_d  = y_q;
        prod_d  = prod_q;   pe_d    = pe_q;    ps_d    = ps_q;
        nan_d   = nan_q;    pzero_d = pzero_q;
        a_mag_d = a_mag_q;  b_mag_d = b_mag_q; ae_d    = ae_q;
        sa_d    = sa_q;     sb_d    = sb_q;
        sum_d   = sum_q;    rs_d    = rs_q;    rzero_d = rzero_q;
        mp = '0; mc = '0; man_n = '0; ep = '0; ec = '0; diff = '0; e_n = '0; lzc = '0;

        case (state_q)
            S_IDLE: if (in_valid) begin
                data_d  = data;
                m_d     = m;
                c_d     = c;
                state_d = S_MUL;
            end
            S_MUL: begin
                prod_d  = PW'({1'b1, man_f(m_q)}) * PW'({1'b1, man_f(data_q)});
                pe_d    = $signed(EW'(exp_f(m_q))) + $signed(EW'(exp_f(data_q))) - BIAS;
                ps_d    = m_q[W-1] ^ data_q[W-1];
                nan_d   = (exp_f(m_q) == E_ONES) || (exp_f(data_q) == E_ONES) ||
                          (exp_f(c_q) == E_ONES);
                pzero_d = (exp_f(m_q) == '0) || (exp_f(data_q) == '0);
                state_d = S_ALIGN;
`ifdef PWL_ZERO_SLOPE_FASTPATH_EN
                if (exp_f(m_q) == '0) begin
                    y_d     = (exp_f(c_q) == E_ONES) ? NAN_W : c_q;
                    state_d = S_DONE;
                end
`endif
            end
            S_ALIGN: begin
                if (prod_q[PW-1]) begin
                    mp = prod_q[PW-1 -: MW];
                    ep = pe_q + ONE_E;
                end else begin
                    mp = prod_q[PW-2 -: MW];
                    ep = pe_q;
                end
                ec   = $signed(EW'(exp_f(c_q)));
                mc   = {1'b1, man_f(c_q)};
                sa_d = ps_q;
                sb_d = c_q[W-1];
                // A flushed-zero intercept must not steal the exponent from the product.
                if (exp_f(c_q) == '0) begin
                    a_mag_d = mp;
                    b_mag_d = '0;
                    ae_d    = ep;
                end else if (ep >= ec) begin
                    diff    = ep - ec;
                    a_mag_d = mp;
                    b_mag_d = (diff >= SHMAX) ? '0 : mc >> diff;
                    ae_d    = ep;
                end else begin
                    diff    = ec - ep;
                    a_mag_d = (diff >= SHMAX) ? '0 : mp >> diff;
                    b_mag_d = mc;
                    ae_d    = ec;
                end
                state_d = S_ADD;
            end
            S_ADD: begin
                if (sa_q == sb_q) begin
                    sum_d = {1'b0, a_mag_q} + {1'b0, b_mag_q};
                    rs_d  = sa_q;
                end else if (a_mag_q >= b_mag_q) begin
                    sum_d = {1'b0, a_mag_q - b_mag_q};
                    rs_d  = sa_q;
                end else begin
                    sum_d = {1'b0, b_mag_q - a_mag_q};
                    rs_d  = sb_q;
                end
                rzero_d = (sum_d == '0);
                state_d = S_NORM;
            end
            S_NORM: begin
                for (int i = 0; i < MW; i++) begin
                    if (sum_q[i]) lzc = LZW'(MW - 1 - i);
                end
                if (sum_q[MW]) begin
                    man_n = sum_q[MW:1];
                    e_n   = ae_q + ONE_E;
                end else begin
                    man_n = sum_q[MW-1:0] << lzc;
                    e_n   = ae_q - $signed({{(EW-LZW){1'b0}}, lzc});
                end
                if (nan_q)              y_d = NAN_W;
                else if (pzero_q)       y_d = c_q;
                else if (rzero_q)       y_d = '0;
                else if (e_n >= EMAX)   y_d = {rs_q, MAXMAG};
                else if (e_n <= ZERO_E) y_d = {rs_q, {(W-1){1'b0}}};
                else                    y_d = {rs_q, e_n[EXP_W-1:0], man_n[MAN_W-1:0]};
                state_d = S_DONE;
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;  m_q     <= '0;  c_q     <= '0;  y_q  <= '0;
            prod_q  <= '0;  pe_q    <= '0;  ps_q    <= 1'b0;
            nan_q   <= 1'b0; pzero_q <= 1'b0;
            a_mag_q <= '0;  b_mag_q <= '0;  ae_q    <= '0;
            sa_q    <= 1'b0; sb_q   <= 1'b0;
            sum_q   <= '0;  rs_q    <= 1'b0; rzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;  m_q     <= m_d;     c_q     <= c_d;     y_q  <= y_d;
            prod_q  <= prod_d;  pe_q    <= pe_d;    ps_q    <= ps_d;
            nan_q   <= nan_d;   pzero_q <= pzero_d;
            a_mag_q <= a_mag_d; b_mag_q <= b_mag_d; ae_q    <= ae_d;
            sa_q    <= sa_d;    sb_q    <= sb_d;
            sum_q   <= sum_d;   rs_q    <= rs_d;    rzero_q <= rzero_d;
        end
    end

    // Truncated product bits and the hidden bit are dropped by design.
    assign unused_bits = ^{prod_q[PW-MW-2:0], man_n[MW-1]};

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign y         = y_q;
endmodule
